tt_pin_host: RTL and testbench

- Host-side driver for the Tiny Tapeout user-project pin interface; the opposite end of that interface from the user design.
- Accepts 12-bit commands over a valid/ready stream. Drives the DUT's ui_in, uio_in, ena, clk and rst_n pins.
- Samples uo_out and the resolved uio bus, and returns 16-bit responses over a second valid/ready stream.
- Used as the synthesizable stimulus engine in tb and in the FPGA bring-up harness around tt10.

---
 rtl/tt_host_pkg.sv | 24 ++
 rtl/tt_clk_gen.sv | 52 +++++
 rtl/tt_pin_host.sv | 137 +++++++++++++
 tb/tb_tt_pin_host.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_host_pkg.sv
// Shared types for the Tiny Tapeout pin host: command opcodes, FSM states and stream widths.
package tt_host_pkg;

  localparam int CMD_W  = 12;
  localparam int RESP_W = 16;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_SET_UI  = 4'd1,
    OP_SET_UIO = 4'd2,
    OP_SET_ENA = 4'd3,
    OP_RESET   = 4'd4,
    OP_STEP    = 4'd5,
    OP_SAMPLE  = 4'd6
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLK_HI,
    ST_CLK_LO,
    ST_RESP
  } state_e;

endpackage

// File: rtl/tt_clk_gen.sv
// Generates n_cycles DUT clock periods of 2*HALF_DIV host cycles each, starting high on the start edge.
// done is high during the last host cycle of the final low phase; half_end marks the last cycle of any phase.
module tt_clk_gen #(
  parameter int HALF_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] n_cycles,
  output logic       dut_clk,
  output logic       half_end,
  output logic       done
);

  localparam logic [7:0] HALF_LOAD = 8'(HALF_DIV - 1);

  logic       running;
  logic [7:0] half_cnt;
  logic [7:0] cyc_left;

  assign half_end = running && (half_cnt == 8'd0);
  assign done     = half_end && !dut_clk && (cyc_left == 8'd0);

  // cyc_left counts the periods still to run after the current one, so 255 never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running  <= 1'b0;
      dut_clk  <= 1'b0;
      half_cnt <= 8'd0;
      cyc_left <= 8'd0;
    end else if (start) begin
      running  <= 1'b1;
      dut_clk  <= 1'b1;
      half_cnt <= HALF_LOAD;
      cyc_left <= n_cycles - 8'd1;
    end else if (running) begin
      if (half_cnt != 8'd0) begin
        half_cnt <= half_cnt - 8'd1;
      end else if (dut_clk) begin
        dut_clk  <= 1'b0;
        half_cnt <= HALF_LOAD;
      end else if (cyc_left == 8'd0) begin
        running <= 1'b0;
      end else begin
        dut_clk  <= 1'b1;
        half_cnt <= HALF_LOAD;
        cyc_left <= cyc_left - 8'd1;
      end
    end
  end

endmodule

// File: rtl/tt_pin_host.sv
// Host-side driver of the Tiny Tapeout pin interface: takes 12-bit commands, drives DUT pins, returns 16-bit samples.
// One command at a time; cmd_ready only in IDLE, responses hold until resp_ready.
module tt_pin_host
  import tt_host_pkg::*;
#(
  parameter int HALF_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [RESP_W-1:0] resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic              dut_clk,
  output logic              dut_rst_n,
  output logic              dut_ena,
  output logic [7:0]        dut_ui_in,
  output logic [7:0]        dut_uio_in,
  input  logic [7:0]        dut_uo_out,
  input  logic [7:0]        dut_uio_out,
  input  logic [7:0]        dut_uio_oe
);

  state_e     state, state_nxt;
  logic [3:0] op;
  logic [7:0] arg;
  logic       accept;
  logic       start;
  logic [7:0] n_cycles;
  logic       half_end;
  logic       done;
  logic       rst_seq;
  logic [7:0] uio_resolved;

  assign op           = cmd_data[11:8];
  assign arg          = cmd_data[7:0];
  assign cmd_ready    = (state == ST_IDLE) && !rst;
  assign accept       = cmd_valid && cmd_ready;
  assign busy         = (state != ST_IDLE);
  assign n_cycles     = (arg == 8'd0) ? 8'd1 : arg;
  assign uio_resolved = (dut_uio_oe & dut_uio_out) | (~dut_uio_oe & dut_uio_in);

  tt_clk_gen #(.HALF_DIV(HALF_DIV)) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n_cycles (n_cycles),
    .dut_clk  (dut_clk),
    .half_end (half_end),
    .done     (done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_NOP, OP_SET_UI, OP_SET_UIO, OP_SET_ENA: state_nxt = ST_IDLE;
            OP_RESET: begin
              start     = 1'b1;
              state_nxt = ST_CLK_HI;
            end
            OP_STEP: begin
              if (arg != 8'd0) begin
                start     = 1'b1;
                state_nxt = ST_CLK_HI;
              end
            end
            default: state_nxt = ST_RESP;
          endcase
        end
      end
      ST_CLK_HI: if (half_end) state_nxt = ST_CLK_LO;
      ST_CLK_LO: begin
        if (done)          state_nxt = ST_IDLE;
        else if (half_end) state_nxt = ST_CLK_HI;
      end
      ST_RESP:   if (resp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // rst_seq remembers that the running clock burst belongs to a RESET, so a STEP never releases rst_n.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_rst_n  <= 1'b0;
      dut_ena    <= 1'b0;
      dut_ui_in  <= 8'd0;
      dut_uio_in <= 8'd0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      rst_seq    <= 1'b0;
    end else begin
      if (accept) begin
        case (op)
          OP_NOP, OP_STEP: begin
          end
          OP_SET_UI:  dut_ui_in  <= arg;
          OP_SET_UIO: dut_uio_in <= arg;
          OP_SET_ENA: dut_ena    <= arg[0];
          OP_RESET: begin
            dut_rst_n <= 1'b0;
            rst_seq   <= 1'b1;
          end
          OP_SAMPLE: begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= {dut_uo_out, uio_resolved};
          end
          default: begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= '0;
          end
        endcase
      end
      if (state == ST_CLK_LO && done && rst_seq) begin
        dut_rst_n <= 1'b1;
        rst_seq   <= 1'b0;
      end
      if (state == ST_RESP && resp_ready) resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tt_pin_host.sv
// Directed bench for tt_pin_host with HALF_DIV=2 and hand-computed expectations.
module tb_tt_pin_host;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_data = 12'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [15:0] resp_data;
  logic        resp_err;
  logic        busy;
  logic        dut_clk;
  logic        dut_rst_n;
  logic        dut_ena;
  logic [7:0]  dut_ui_in;
  logic [7:0]  dut_uio_in;
  logic [7:0]  dut_uo_out = 8'd0;
  logic [7:0]  dut_uio_out = 8'd0;
  logic [7:0]  dut_uio_oe = 8'd0;

  int vectors = 0;
  int miscompares = 0;

  tt_pin_host #(.HALF_DIV(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .busy        (busy),
    .dut_clk     (dut_clk),
    .dut_rst_n   (dut_rst_n),
    .dut_ena     (dut_ena),
    .dut_ui_in   (dut_ui_in),
    .dut_uio_in  (dut_uio_in),
    .dut_uo_out  (dut_uo_out),
    .dut_uio_out (dut_uio_out),
    .dut_uio_oe  (dut_uio_oe)
  );

  always #5 clk = ~clk;

  // Offers a command and returns 1 ns after the edge that accepted it.
  task automatic send(input logic [3:0] op, input logic [7:0] arg);
    int w = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = {op, arg};
    while (!cmd_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    if (w >= 2000) begin
      miscompares++;
      $display("FAIL send_timeout op=%0h: cmd_ready never rose", op);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({cmd_ready, dut_clk, dut_rst_n, dut_ena, resp_valid, resp_err, busy} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctl got=%b want=0000000",
               {cmd_ready, dut_clk, dut_rst_n, dut_ena, resp_valid, resp_err, busy});
    end
    vectors++;
    if ({dut_ui_in, dut_uio_in, resp_data} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data got=%h want=00000000", {dut_ui_in, dut_uio_in, resp_data});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready got=%b want=1", cmd_ready);
    end
  endtask

  task automatic test_set_ui();
    send(4'h1, 8'hA5);
    vectors++;
    if ({dut_ui_in, dut_uio_in, dut_ena, dut_rst_n} !== {8'hA5, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL set_ui got=%h/%h/%b/%b want=a5/00/0/0", dut_ui_in, dut_uio_in, dut_ena, dut_rst_n);
    end
  endtask

  task automatic test_reset_seq();
    int rises = 0;
    logic prev = 1'b0;
    send(4'h4, 8'd3);
    for (int k = 0; k <= 12; k++) begin
      logic exp_clk;
      exp_clk = (k < 12) && ((k % 4) < 2);
      if (dut_clk && !prev) rises++;
      prev = dut_clk;
      vectors++;
      if ({dut_clk, dut_rst_n, cmd_ready} !== {exp_clk, k == 12, k == 12}) begin
        miscompares++;
        $display("FAIL reset_seq k=%0d clk/rst_n/ready got=%b%b%b want=%b%b%b",
                 k, dut_clk, dut_rst_n, cmd_ready, exp_clk, k == 12, k == 12);
      end
      @(posedge clk);
      #1;
    end
    vectors++;
    if (rises !== 3) begin
      miscompares++;
      $display("FAIL reset_pulses got=%0d want=3", rises);
    end
  endtask

  task automatic test_sample();
    send(4'h2, 8'h0F);
    dut_uio_oe  = 8'hF0;
    dut_uio_out = 8'h3C;
    dut_uo_out  = 8'h81;
    send(4'h6, 8'h00);
    dut_uo_out = 8'h22;
    vectors++;
    if ({resp_valid, resp_err, cmd_ready, busy, resp_data} !== {4'b1001, 16'h813F}) begin
      miscompares++;
      $display("FAIL sample got=%b%b%b%b %h want=1001 813f", resp_valid, resp_err, cmd_ready, busy, resp_data);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({resp_valid, cmd_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL sample_handshake valid/ready got=%b%b want=01", resp_valid, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    dut_uo_out = 8'h81;
    resp_ready = 1'b0;
    send(4'h6, 8'h00);
    dut_uo_out = 8'h22;
    cmd_valid  = 1'b1;
    cmd_data   = {4'h1, 8'h3C};
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({resp_valid, cmd_ready, resp_data, dut_ui_in} !== {2'b10, 16'h813F, 8'hA5}) begin
        miscompares++;
        $display("FAIL backpressure k=%0d got=%b%b %h %h want=10 813f a5",
                 k, resp_valid, cmd_ready, resp_data, dut_ui_in);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({resp_valid, cmd_ready, dut_ui_in} !== {2'b01, 8'hA5}) begin
      miscompares++;
      $display("FAIL bp_release got=%b%b %h want=01 a5", resp_valid, cmd_ready, dut_ui_in);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    vectors++;
    if (dut_ui_in !== 8'h3C) begin
      miscompares++;
      $display("FAIL held_cmd got=%h want=3c", dut_ui_in);
    end
  endtask

  task automatic test_illegal_and_step0();
    int rises = 0;
    send(4'hB, 8'h77);
    vectors++;
    if ({resp_valid, resp_err, resp_data} !== {2'b11, 16'h0000}) begin
      miscompares++;
      $display("FAIL illegal got=%b%b %h want=11 0000", resp_valid, resp_err, resp_data);
    end
    @(posedge clk);
    #1;
    send(4'h5, 8'h00);
    vectors++;
    if ({cmd_ready, busy, resp_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL step0 ready/busy/valid got=%b%b%b want=100", cmd_ready, busy, resp_valid);
    end
    for (int k = 0; k < 4; k++) begin
      if (dut_clk) rises++;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (rises !== 0) begin
      miscompares++;
      $display("FAIL step0_clk high_samples got=%0d want=0", rises);
    end
  endtask

  task automatic test_rst_mid_step();
    send(4'h5, 8'd255);
    repeat (37) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if ({dut_clk, busy, dut_rst_n} !== 3'b111) begin
      miscompares++;
      $display("FAIL step_cycle10 clk/busy/rst_n got=%b%b%b want=111", dut_clk, busy, dut_rst_n);
    end
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({dut_clk, dut_rst_n, busy, cmd_ready, resp_valid} !== 5'b0) begin
      miscompares++;
      $display("FAIL mid_step_rst got=%b want=00000", {dut_clk, dut_rst_n, busy, cmd_ready, resp_valid});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({dut_clk, busy, cmd_ready, resp_valid} !== 4'b0010) begin
      miscompares++;
      $display("FAIL after_rst got=%b want=0010", {dut_clk, busy, cmd_ready, resp_valid});
    end
  endtask

  initial begin
    test_reset();
    test_set_ui();
    test_reset_seq();
    test_sample();
    test_back_to_back();
    test_illegal_and_step0();
    test_rst_mid_step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
